// File: rtl/pc_redirect_unit.sv
// -----------------------------------------------------------------------------
// pc_redirect_unit
//
// Fetch-stage program counter with prioritised redirects, stall hold, a
// single-entry pending-redirect register for redirects that arrive during a
// stall, and a small circular return-address stack (RAS).
//
// Ports:
//   clk_i           in   1       clock, all state changes on the rising edge
//   rst_i           in   1       synchronous active-high reset
//   stall_i         in   1       hold the PC this cycle
//   exc_i           in   1       exception redirect to EXC_VEC (ignores stall)
//   branch_i        in   1       resolved taken branch
//   branch_target_i in   ADDR_W  branch target
//   jump_i          in   1       jump from decode
//   call_i          in   1       qualifies jump_i as a call (pushes link_i)
//   jump_target_i   in   ADDR_W  jump / call target
//   link_i          in   ADDR_W  return address pushed on a call
//   ret_i           in   1       return, target is the RAS top
//   pc_o            out  ADDR_W  current fetch PC
//   flush_o         out  1       pulse in the cycle a redirect shows on pc_o
//   ras_empty_o     out  1       RAS holds no entries
//   ras_full_o      out  1       RAS holds RAS_DEPTH entries
//   ret_miss_o      out  1       pulse: a return found the RAS empty
// -----------------------------------------------------------------------------
module pc_redirect_unit #(
    parameter int unsigned            ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]      RESET_VEC = 32'h0000_0000,
    parameter logic [ADDR_W-1:0]      EXC_VEC   = 32'h0000_0080,
    parameter int unsigned            INC       = 32'd4,
    parameter int unsigned            RAS_DEPTH = 32'd4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              exc_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic              call_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    input  logic [ADDR_W-1:0] link_i,
    input  logic              ret_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              flush_o,
    output logic              ras_empty_o,
    output logic              ras_full_o,
    output logic              ret_miss_o
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 32'd1) ? $clog2(RAS_DEPTH) : 32'd1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 32'd1);

    localparam logic [ADDR_W-1:0] INC_V    = ADDR_W'(INC);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RAS_DEPTH);

    // Source rank of a redirect, used to decide whether a new redirect during
    // a stall may replace the one already waiting.
    localparam logic [1:0] PRI_JUMP   = 2'd0;
    localparam logic [1:0] PRI_RET    = 2'd1;
    localparam logic [1:0] PRI_BRANCH = 2'd2;

    // Architectural state
    logic [ADDR_W-1:0] pc_r;
    logic              flush_r;
    logic              ret_miss_r;
    logic              pend_valid_r;
    logic [ADDR_W-1:0] pend_target_r;
    logic [1:0]        pend_pri_r;
    logic [ADDR_W-1:0] ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_top_r;
    logic [CNT_W-1:0]  ras_count_r;

    // Per-cycle decode
    logic              req_valid_s;
    logic [ADDR_W-1:0] req_target_s;
    logic [1:0]        req_pri_s;
    logic              do_push_s;
    logic              do_pop_s;
    logic              miss_s;
    logic [PTR_W-1:0]  push_idx_s;

    // Next-state values
    logic [ADDR_W-1:0] next_pc_s;
    logic              next_flush_s;
    logic              next_pend_valid_s;
    logic [ADDR_W-1:0] next_pend_target_s;
    logic [1:0]        next_pend_pri_s;

    // Select this cycle's redirect request and RAS operation by source priority.
    always_comb begin
        req_valid_s  = 1'b0;
        req_target_s = pc_r;
        req_pri_s    = PRI_JUMP;
        do_push_s    = 1'b0;
        do_pop_s     = 1'b0;
        miss_s       = 1'b0;
        push_idx_s   = ras_top_r + PTR_ONE;
        if (exc_i) begin
            // Exception handled in the next-PC block; every RAS op is dropped.
            req_valid_s = 1'b0;
        end else if (branch_i) begin
            req_valid_s  = 1'b1;
            req_target_s = branch_target_i;
            req_pri_s    = PRI_BRANCH;
        end else if (ret_i) begin
            // A return squashes a same-cycle jump even when it cannot redirect.
            if (ras_count_r != CNT_ZERO) begin
                req_valid_s  = 1'b1;
                req_target_s = ras_mem_r[ras_top_r];
                req_pri_s    = PRI_RET;
                do_pop_s     = 1'b1;
            end else begin
                miss_s = 1'b1;
            end
        end else if (jump_i) begin
            req_valid_s  = 1'b1;
            req_target_s = jump_target_i;
            req_pri_s    = PRI_JUMP;
            do_push_s    = call_i;
        end else begin
            req_valid_s = 1'b0;
        end
    end

    // Compute next PC, flush pulse and pending-redirect register contents.
    always_comb begin
        next_pc_s          = pc_r;
        next_flush_s       = 1'b0;
        next_pend_valid_s  = pend_valid_r;
        next_pend_target_s = pend_target_r;
        next_pend_pri_s    = pend_pri_r;
        if (exc_i) begin
            next_pc_s         = EXC_VEC;
            next_flush_s      = 1'b1;
            next_pend_valid_s = 1'b0;
        end else if (stall_i) begin
            // PC holds; a redirect of at least the waiting one's rank replaces it.
            if (req_valid_s && (!pend_valid_r || (req_pri_s >= pend_pri_r))) begin
                next_pend_valid_s  = 1'b1;
                next_pend_target_s = req_target_s;
                next_pend_pri_s    = req_pri_s;
            end else begin
                next_pend_valid_s = pend_valid_r;
            end
        end else if (req_valid_s) begin
            next_pc_s         = req_target_s;
            next_flush_s      = 1'b1;
            next_pend_valid_s = 1'b0;
        end else if (pend_valid_r) begin
            next_pc_s         = pend_target_r;
            next_flush_s      = 1'b1;
            next_pend_valid_s = 1'b0;
        end else begin
            // Wraps modulo 2^ADDR_W.
            next_pc_s = pc_r + INC_V;
        end
    end

    // PC, pulse outputs and pending-redirect registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_r          <= RESET_VEC;
            flush_r       <= 1'b0;
            ret_miss_r    <= 1'b0;
            pend_valid_r  <= 1'b0;
            pend_target_r <= RESET_VEC;
            pend_pri_r    <= PRI_JUMP;
        end else begin
            pc_r          <= next_pc_s;
            flush_r       <= next_flush_s;
            ret_miss_r    <= miss_s;
            pend_valid_r  <= next_pend_valid_s;
            pend_target_r <= next_pend_target_s;
            pend_pri_r    <= next_pend_pri_s;
        end
    end

    // Circular return-address stack; a push when full overwrites the oldest slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ras_top_r   <= PTR_W'(0);
            ras_count_r <= CNT_ZERO;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_mem_r[i] <= RESET_VEC;
            end
        end else if (exc_i) begin
            ras_count_r <= CNT_ZERO;
        end else if (do_pop_s) begin
            ras_top_r   <= ras_top_r - PTR_ONE;
            ras_count_r <= ras_count_r - CNT_ONE;
        end else if (do_push_s) begin
            ras_top_r             <= push_idx_s;
            ras_mem_r[push_idx_s] <= link_i;
            if (ras_count_r != CNT_FULL) begin
                ras_count_r <= ras_count_r + CNT_ONE;
            end else begin
                ras_count_r <= CNT_FULL;
            end
        end else begin
            ras_count_r <= ras_count_r;
        end
    end

    assign pc_o        = pc_r;
    assign flush_o     = flush_r;
    assign ret_miss_o  = ret_miss_r;
    assign ras_empty_o = (ras_count_r == CNT_ZERO);
    assign ras_full_o  = (ras_count_r == CNT_FULL);

endmodule

// File: tb/tb_pc_redirect_unit.sv
// -----------------------------------------------------------------------------
// Testbench for pc_redirect_unit: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model that keeps the
// RAS as a queue and the PC as a plain number.
// -----------------------------------------------------------------------------
module tb_pc_redirect_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RVEC  = 32'h0000_0000;
    localparam logic [31:0] EVEC  = 32'h0000_0080;
    localparam logic [31:0] STEP  = 32'd4;

    logic        clk = 1'b0;
    logic        rst_i, stall_i, exc_i, branch_i, jump_i, call_i, ret_i;
    logic [31:0] branch_target_i, jump_target_i, link_i;
    logic [31:0] pc_o;
    logic        flush_o, ras_empty_o, ras_full_o, ret_miss_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_flush, m_miss;
    logic [31:0] ras_q[$];
    logic        m_pv;
    logic [31:0] m_pt;
    int          m_pp;

    pc_redirect_unit #(
        .ADDR_W(32), .RESET_VEC(RVEC), .EXC_VEC(EVEC), .INC(4), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .exc_i(exc_i),
        .branch_i(branch_i), .branch_target_i(branch_target_i),
        .jump_i(jump_i), .call_i(call_i), .jump_target_i(jump_target_i),
        .link_i(link_i), .ret_i(ret_i), .pc_o(pc_o), .flush_o(flush_o),
        .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o), .ret_miss_o(ret_miss_o)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rst_i = 1'b0; stall_i = 1'b0; exc_i = 1'b0; branch_i = 1'b0;
        jump_i = 1'b0; call_i = 1'b0; ret_i = 1'b0;
        branch_target_i = 32'd0; jump_target_i = 32'd0; link_i = 32'd0;
    endtask

    // Apply the documented rules to the current inputs.
    task automatic model_step();
        bit          rv;
        logic [31:0] rt;
        int          rp;
        rv = 1'b0; rt = 32'd0; rp = 0;
        if (rst_i) begin
            m_pc = RVEC; m_flush = 1'b0; m_miss = 1'b0; ras_q.delete(); m_pv = 1'b0;
        end else if (exc_i) begin
            m_pc = EVEC; m_flush = 1'b1; m_miss = 1'b0; ras_q.delete(); m_pv = 1'b0;
        end else begin
            m_miss = 1'b0;
            if (branch_i) begin
                rv = 1'b1; rt = branch_target_i; rp = 2;
            end else if (ret_i) begin
                if (ras_q.size() > 0) begin
                    rv = 1'b1; rt = ras_q.pop_back(); rp = 1;
                end else begin
                    m_miss = 1'b1;
                end
            end else if (jump_i) begin
                rv = 1'b1; rt = jump_target_i; rp = 0;
                if (call_i) begin
                    ras_q.push_back(link_i);
                    if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
                end
            end
            m_flush = 1'b0;
            if (stall_i) begin
                if (rv && (!m_pv || rp >= m_pp)) begin
                    m_pv = 1'b1; m_pt = rt; m_pp = rp;
                end
            end else if (rv) begin
                m_pc = rt; m_flush = 1'b1; m_pv = 1'b0;
            end else if (m_pv) begin
                m_pc = m_pt; m_flush = 1'b1; m_pv = 1'b0;
            end else begin
                m_pc = m_pc + STEP;
            end
        end
    endtask

    // One clock: update model, let the edge pass, compare all outputs.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_value("pc", pc_o, m_pc);
        check_value("flush", {31'd0, flush_o}, {31'd0, m_flush});
        check_value("ret_miss", {31'd0, ret_miss_o}, {31'd0, m_miss});
        check_value("ras_empty", {31'd0, ras_empty_o}, {31'd0, ras_q.size() == 0});
        check_value("ras_full", {31'd0, ras_full_o}, {31'd0, ras_q.size() == DEPTH});
        clear_inputs();
    endtask

    task automatic go_to(input logic [31:0] addr);
        branch_i = 1'b1; branch_target_i = addr;
        tick();
    endtask

    initial begin
        m_pc = 32'd0; m_flush = 1'b0; m_miss = 1'b0; m_pv = 1'b0; m_pt = 32'd0; m_pp = 0;
        clear_inputs();
        @(negedge clk);

        // Reset, then free-running sequence
        rst_i = 1'b1; tick();
        check_value("rst_pc", pc_o, 32'h0);
        tick(); check_value("seq1", pc_o, 32'h4);
        tick(); check_value("seq2", pc_o, 32'h8);
        tick(); check_value("seq3", pc_o, 32'hC);
        tick(); check_value("seq4", pc_o, 32'h10);

        // Branch beats a same-cycle jump
        branch_i = 1'b1; branch_target_i = 32'h200;
        jump_i = 1'b1; call_i = 1'b1; jump_target_i = 32'h300; link_i = 32'h14;
        tick();
        check_value("br_pc", pc_o, 32'h200);
        check_value("br_flush", {31'd0, flush_o}, 32'd1);
        check_value("br_ras", {31'd0, ras_empty_o}, 32'd1);
        tick();
        check_value("br_flush_off", {31'd0, flush_o}, 32'd0);

        // Jump arriving during a three-cycle stall
        go_to(32'h40);
        stall_i = 1'b1; tick();
        stall_i = 1'b1; jump_i = 1'b1; jump_target_i = 32'h100; tick();
        stall_i = 1'b1; tick();
        check_value("stall_hold", pc_o, 32'h40);
        tick();
        check_value("stall_rel", pc_o, 32'h100);
        check_value("stall_flush", {31'd0, flush_o}, 32'd1);
        tick();
        check_value("stall_seq", pc_o, 32'h104);

        // Five calls into a four-entry RAS, then five returns
        for (int i = 0; i < 5; i++) begin
            jump_i = 1'b1; call_i = 1'b1; jump_target_i = 32'h1000 + 32'(i) * 32'h100;
            link_i = 32'hA0 + 32'(i) * 32'h10;
            tick();
            if (i == 3) check_value("ras_full4", {31'd0, ras_full_o}, 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            ret_i = 1'b1; tick();
            check_value("ret_tgt", pc_o, 32'hE0 - 32'(i) * 32'h10);
        end
        ret_i = 1'b1; tick();
        check_value("ret_miss", {31'd0, ret_miss_o}, 32'd1);
        check_value("ret_miss_pc", pc_o, 32'hB4);

        // Exception during a stall with a pending branch and two RAS entries
        jump_i = 1'b1; call_i = 1'b1; jump_target_i = 32'h500; link_i = 32'h11; tick();
        jump_i = 1'b1; call_i = 1'b1; jump_target_i = 32'h600; link_i = 32'h22; tick();
        stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h900; tick();
        stall_i = 1'b1; exc_i = 1'b1; tick();
        check_value("exc_pc", pc_o, 32'h80);
        check_value("exc_empty", {31'd0, ras_empty_o}, 32'd1);
        check_value("exc_flush", {31'd0, flush_o}, 32'd1);
        tick();
        check_value("exc_nopend", pc_o, 32'h84);

        // Reset mid-stall with a pending redirect near the wrap point
        go_to(32'hFFFF_FFFC);
        stall_i = 1'b1; jump_i = 1'b1; jump_target_i = 32'h700; tick();
        rst_i = 1'b1; stall_i = 1'b1; tick();
        check_value("rst_mid_pc", pc_o, RVEC);
        check_value("rst_mid_flush", {31'd0, flush_o}, 32'd0);
        tick();
        check_value("rst_nopend", pc_o, 32'h4);
        go_to(32'hFFFF_FFFC);
        tick();
        check_value("wrap", pc_o, 32'h0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst_i           = ($urandom_range(0, 199) == 0);
            stall_i         = ($urandom_range(0, 3) == 0);
            exc_i           = ($urandom_range(0, 39) == 0);
            branch_i        = ($urandom_range(0, 9) == 0);
            jump_i          = ($urandom_range(0, 4) == 0);
            call_i          = ($urandom_range(0, 1) == 0);
            ret_i           = ($urandom_range(0, 5) == 0);
            branch_target_i = $urandom() & 32'hFFFF_FFFC;
            jump_target_i   = $urandom() & 32'hFFFF_FFFC;
            link_i          = $urandom() & 32'hFFFF_FFFC;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
